// File: rtl/ula_pkg.sv
// Shared ULA definitions: divider FSM states and a wide two's-complement negation
// that narrower datapaths use by zero-extending their operand and truncating the result.
package ula_pkg;

  localparam int DIV_MAX_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_t;

  function automatic logic [DIV_MAX_W-1:0] twos_neg(input logic [DIV_MAX_W-1:0] x);
    return ~x + DIV_MAX_W'(1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between the datapath (master) and the sequential divider (slave).
interface seq_divider_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic         op_signed;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;

  modport master (
    output in_valid, op_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, busy
  );

  modport slave (
    input  in_valid, op_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, busy
  );
endinterface

// File: rtl/rippleSubAdder.sv
// Ripple-carry adder/subtractor: d=1 computes a-b (cout=1 means no borrow), d=0 computes a+b.
module rippleSubAdder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         d,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N-1:0] bx;

  assign bx = b ^ {N{d}};

  always_comb begin
    logic carry;
    s     = '0;
    carry = d;
    for (int i = 0; i < N; i++) begin
      s[i]  = a[i] ^ bx[i] ^ carry;
      carry = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_divider.sv
// Restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle; result after N+3 cycles
// (2 for divide-by-zero / signed overflow). Result is held with out_valid until out_ready.
module seq_divider
  import ula_pkg::*;
#(
  parameter int N = 64
) (
  input  logic           clk,
  input  logic           reset,
  seq_divider_if.slave   io
);

  localparam int           CNT_W   = $clog2(N);
  localparam logic [N-1:0] INT_MIN = {1'b1, {(N-1){1'b0}}};

  div_state_t   state_q, state_d;
  logic [N-1:0] dvd_q, dvd_d;
  logic [N-1:0] dvs_q, dvs_d;
  logic         sgn_q, sgn_d;
  logic [N-1:0] r_q, r_d;
  logic [N-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         neg_quo_q, neg_quo_d;
  logic         neg_rem_q, neg_rem_d;
  logic [N-1:0] quotient_q, quotient_d;
  logic [N-1:0] remainder_q, remainder_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic         in_ready_q, in_ready_d;

  logic [N:0]   trial_t;
  logic [N:0]   add_b;
  logic [N:0]   add_diff;
  logic         add_cout;
  logic [N-1:0] mag_a;
  logic [N-1:0] mag_b;
  logic         unused_diff_msb;

  function automatic logic [N-1:0] neg_n(input logic [N-1:0] x);
    logic [DIV_MAX_W-1:0] wide;
    wide        = '0;
    wide[N-1:0] = x;
    wide        = twos_neg(wide);
    return wide[N-1:0];
  endfunction

  // Partial remainder never reaches 2^N, so the difference MSB carries no information.
  assign trial_t         = {r_q, q_q[N-1]};
  assign add_b           = {1'b0, dvs_q};
  assign unused_diff_msb = add_diff[N];

  rippleSubAdder #(.N(N+1)) u_trial_sub (
    .a    (trial_t),
    .b    (add_b),
    .d    (1'b1),
    .s    (add_diff),
    .cout (add_cout)
  );

  assign mag_a = (sgn_q && dvd_q[N-1]) ? neg_n(dvd_q) : dvd_q;
  assign mag_b = (sgn_q && dvs_q[N-1]) ? neg_n(dvs_q) : dvs_q;

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    sgn_d       = sgn_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          dvd_d   = io.dividend;
          dvs_d   = io.divisor;
          sgn_d   = io.op_signed;
          state_d = PREP;
        end
      end
      PREP: begin
        r_d       = '0;
        q_d       = mag_a;
        dvs_d     = mag_b;
        cnt_d     = CNT_W'(N - 1);
        neg_quo_d = sgn_q & (dvd_q[N-1] ^ dvs_q[N-1]);
        neg_rem_d = sgn_q & dvd_q[N-1];
        if (dvs_q == '0) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
          state_d     = DONE;
        end else if (sgn_q && dvd_q == INT_MIN && (&dvs_q)) begin
          quotient_d  = dvd_q;
          remainder_d = '0;
          state_d     = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        if (add_cout) begin
          r_d = add_diff[N-1:0];
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          r_d = trial_t[N-1:0];
          q_d = {q_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d  = neg_quo_q ? neg_n(q_q) : q_q;
        remainder_d = neg_rem_q ? neg_n(r_q) : r_q;
        state_d     = DONE;
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      sgn_q       <= 1'b0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      sgn_q       <= sgn_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = busy_q;
  assign io.quotient  = quotient_q;
  assign io.remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=64): results, latency, backpressure and async reset.
module tb_seq_divider;

  localparam int N = 64;
  localparam logic [N-1:0] ALL1    = '1;
  localparam logic [N-1:0] INT_MIN = {1'b1, {(N-1){1'b0}}};

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  seq_divider_if #(.N(N)) dif ();

  seq_divider #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (dif)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    dif.in_valid  = 1'b1;
    dif.op_signed = sgn;
    dif.dividend  = a;
    dif.divisor   = b;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle following the accept edge.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (dif.out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (dif.out_valid !== 1'b1) cyc = -1;
  endtask

  task automatic consume;
    @(negedge clk);
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (dif.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b want=1", dif.in_ready); else n_pass++;
    n_checks++; if (dif.busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", dif.busy); else n_pass++;
    n_checks++; if (dif.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", dif.out_valid); else n_pass++;
    n_checks++; if (dif.quotient !== 64'd0) $display("FAIL rst_quotient got=%h want=0", dif.quotient); else n_pass++;
    n_checks++; if (dif.remainder !== 64'd0) $display("FAIL rst_remainder got=%h want=0", dif.remainder); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_divu;
    int cyc;
    start_op(1'b0, 64'd100, 64'd7);
    n_checks++; if (dif.busy !== 1'b1) $display("FAIL divu_busy got=%b want=1", dif.busy); else n_pass++;
    // operand and request changes while busy must not disturb the running division
    dif.dividend = 64'd12345;
    dif.divisor  = 64'd3;
    dif.in_valid = 1'b1;
    wait_valid(cyc);
    dif.in_valid = 1'b0;
    n_checks++; if (cyc !== 67) $display("FAIL divu_latency got=%0d want=67", cyc); else n_pass++;
    n_checks++; if (dif.quotient !== 64'd14) $display("FAIL divu_q got=%h want=%h", dif.quotient, 64'd14); else n_pass++;
    n_checks++; if (dif.remainder !== 64'd2) $display("FAIL divu_r got=%h want=%h", dif.remainder, 64'd2); else n_pass++;
    consume;
  endtask

  task automatic test_signed;
    int cyc;
    start_op(1'b1, -64'sd7, 64'd2);
    wait_valid(cyc);
    n_checks++; if (cyc !== 67) $display("FAIL div_m7_2_latency got=%0d want=67", cyc); else n_pass++;
    n_checks++; if (dif.quotient !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_m7_2_q got=%h want=fffffffffffffffd", dif.quotient); else n_pass++;
    n_checks++; if (dif.remainder !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL div_m7_2_r got=%h want=ffffffffffffffff", dif.remainder); else n_pass++;
    consume;
    start_op(1'b1, 64'd7, -64'sd2);
    wait_valid(cyc);
    n_checks++; if (cyc !== 67) $display("FAIL div_7_m2_latency got=%0d want=67", cyc); else n_pass++;
    n_checks++; if (dif.quotient !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_7_m2_q got=%h want=fffffffffffffffd", dif.quotient); else n_pass++;
    n_checks++; if (dif.remainder !== 64'd1) $display("FAIL div_7_m2_r got=%h want=1", dif.remainder); else n_pass++;
    consume;
  endtask

  task automatic test_div_zero;
    int cyc;
    for (int s = 0; s < 2; s++) begin
      start_op(s[0], 64'd5, 64'd0);
      wait_valid(cyc);
      n_checks++; if (cyc !== 2) $display("FAIL div0_latency sgn=%0d got=%0d want=2", s, cyc); else n_pass++;
      n_checks++; if (dif.quotient !== ALL1) $display("FAIL div0_q sgn=%0d got=%h want=%h", s, dif.quotient, ALL1); else n_pass++;
      n_checks++; if (dif.remainder !== 64'd5) $display("FAIL div0_r sgn=%0d got=%h want=5", s, dif.remainder); else n_pass++;
      consume;
    end
  endtask

  task automatic test_overflow;
    int cyc;
    start_op(1'b1, INT_MIN, ALL1);
    wait_valid(cyc);
    n_checks++; if (cyc !== 2) $display("FAIL ovf_latency got=%0d want=2", cyc); else n_pass++;
    n_checks++; if (dif.quotient !== INT_MIN) $display("FAIL ovf_q got=%h want=%h", dif.quotient, INT_MIN); else n_pass++;
    n_checks++; if (dif.remainder !== 64'd0) $display("FAIL ovf_r got=%h want=0", dif.remainder); else n_pass++;
    consume;
    start_op(1'b0, INT_MIN, ALL1);
    wait_valid(cyc);
    n_checks++; if (cyc !== 67) $display("FAIL ovfu_latency got=%0d want=67", cyc); else n_pass++;
    n_checks++; if (dif.quotient !== 64'd0) $display("FAIL ovfu_q got=%h want=0", dif.quotient); else n_pass++;
    n_checks++; if (dif.remainder !== INT_MIN) $display("FAIL ovfu_r got=%h want=%h", dif.remainder, INT_MIN); else n_pass++;
    consume;
  endtask

  task automatic test_backpressure;
    int cyc;
    start_op(1'b0, 64'd1000, 64'd10);
    wait_valid(cyc);
    n_checks++; if (cyc !== 67) $display("FAIL bp_latency got=%0d want=67", cyc); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dif.in_valid = 1'b1;
      dif.dividend = 64'(i + 50);
      dif.divisor  = 64'd1;
      @(posedge clk);
      #1;
      n_checks++; if (dif.out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got=%b want=1", i, dif.out_valid); else n_pass++;
      n_checks++; if (dif.quotient !== 64'd100 || dif.remainder !== 64'd0) $display("FAIL bp_hold[%0d] got=%h/%h want=64/0", i, dif.quotient, dif.remainder); else n_pass++;
      n_checks++; if (dif.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got=%b want=0", i, dif.in_ready); else n_pass++;
    end
    @(negedge clk);
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
    n_checks++; if (dif.out_valid !== 1'b0) $display("FAIL bp_release_valid got=%b want=0", dif.out_valid); else n_pass++;
    n_checks++; if (dif.in_ready !== 1'b1 || dif.busy !== 1'b0) $display("FAIL bp_release_idle got=ready%b/busy%b want=1/0", dif.in_ready, dif.busy); else n_pass++;
    n_checks++; if (dif.quotient !== 64'd100) $display("FAIL bp_keep_q got=%h want=64", dif.quotient); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    dif.out_ready = 1'b1;
    start_op(1'b0, 64'd9, 64'd3);
    wait_valid(cyc);
    n_checks++; if (cyc !== 67) $display("FAIL b2b_a_latency got=%0d want=67", cyc); else n_pass++;
    n_checks++; if (dif.quotient !== 64'd3 || dif.remainder !== 64'd0) $display("FAIL b2b_a_result got=%h/%h want=3/0", dif.quotient, dif.remainder); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (dif.out_valid !== 1'b0) $display("FAIL b2b_a_one_cycle got=%b want=0", dif.out_valid); else n_pass++;
    n_checks++; if (dif.in_ready !== 1'b1) $display("FAIL b2b_ready_rise got=%b want=1", dif.in_ready); else n_pass++;
    start_op(1'b1, -64'sd20, 64'd6);
    wait_valid(cyc);
    n_checks++; if (cyc !== 67) $display("FAIL b2b_b_latency got=%0d want=67", cyc); else n_pass++;
    n_checks++; if (dif.quotient !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL b2b_b_q got=%h want=fffffffffffffffd", dif.quotient); else n_pass++;
    n_checks++; if (dif.remainder !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL b2b_b_r got=%h want=fffffffffffffffe", dif.remainder); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (dif.out_valid !== 1'b0) $display("FAIL b2b_b_one_cycle got=%b want=0", dif.out_valid); else n_pass++;
    dif.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_iter;
    int cyc;
    start_op(1'b0, ALL1, 64'd7);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_checks++; if (dif.busy !== 1'b0) $display("FAIL midrst_busy got=%b want=0", dif.busy); else n_pass++;
    n_checks++; if (dif.out_valid !== 1'b0) $display("FAIL midrst_valid got=%b want=0", dif.out_valid); else n_pass++;
    n_checks++; if (dif.quotient !== 64'd0) $display("FAIL midrst_q got=%h want=0", dif.quotient); else n_pass++;
    n_checks++; if (dif.remainder !== 64'd0) $display("FAIL midrst_r got=%h want=0", dif.remainder); else n_pass++;
    n_checks++; if (dif.in_ready !== 1'b1) $display("FAIL midrst_in_ready got=%b want=1", dif.in_ready); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    start_op(1'b0, ALL1, 64'd1);
    wait_valid(cyc);
    n_checks++; if (cyc !== 67) $display("FAIL postrst_latency got=%0d want=67", cyc); else n_pass++;
    n_checks++; if (dif.quotient !== ALL1) $display("FAIL postrst_q got=%h want=%h", dif.quotient, ALL1); else n_pass++;
    n_checks++; if (dif.remainder !== 64'd0) $display("FAIL postrst_r got=%h want=0", dif.remainder); else n_pass++;
    consume;
  endtask

  initial begin
    dif.in_valid  = 1'b0;
    dif.op_signed = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.out_ready = 1'b0;
    test_reset;
    test_divu;
    test_signed;
    test_div_zero;
    test_overflow;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_iter;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
